// File: rtl/pattern_gen.sv
// Pattern generator: up/down count, walking-one or Gray words on a valid/ready output.
// Define PATTERN_GEN_ONESHOT_EN to stop after one full pattern period per start.
module pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             wrapped,
    output logic [1:0]       dbg_state
);

    // Handshake: a word transfers in any cycle where out_valid and out_ready
    // are both high; once raised, out_valid and out_data hold until that cycle.
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESENT = 2'd1;
    localparam logic [1:0] GAP     = 2'd2;

    localparam logic [7:0] GAP_LAST = (DIV > 1) ? 8'(DIV - 2) : 8'd0;

    logic [1:0]       state;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] bin;
    logic [7:0]       presc;
    logic             stop_pend;

    logic             accept;
    logic             last_word;
    logic             oneshot_end;
    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_data;
    logic [WIDTH-1:0] seed_data;

    assign accept    = (state == PRESENT) && out_ready;
    assign out_valid = (state == PRESENT);
    assign busy      = (state != IDLE);
    assign wrapped   = accept && last_word;
    assign dbg_state = state;

`ifdef PATTERN_GEN_ONESHOT_EN
    assign oneshot_end = last_word;
`else
    assign oneshot_end = 1'b0;
`endif

    always_comb begin
        next_bin  = bin + WIDTH'(1);
        next_data = out_data;
        last_word = 1'b0;
        case (mode_q)
            2'b00: begin
                next_data = out_data + WIDTH'(1);
                last_word = (out_data == {WIDTH{1'b1}});
            end
            2'b01: begin
                next_data = out_data - WIDTH'(1);
                last_word = (out_data == '0);
            end
            2'b10: begin
                next_data = {out_data[WIDTH-2:0], out_data[WIDTH-1]};
                last_word = out_data[WIDTH-1];
            end
            default: begin
                next_data = next_bin ^ (next_bin >> 1);
                last_word = (bin == {WIDTH{1'b1}});
            end
        endcase
    end

    always_comb begin
        seed_data = '0;
        case (mode)
            2'b01:   seed_data = {WIDTH{1'b1}};
            2'b10:   seed_data = WIDTH'(1);
            default: seed_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= 2'b00;
            out_data  <= '0;
            bin       <= '0;
            presc     <= 8'd0;
            stop_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state     <= PRESENT;
                        mode_q    <= mode;
                        out_data  <= seed_data;
                        bin       <= '0;
                        presc     <= 8'd0;
                        stop_pend <= 1'b0;
                    end
                end
                PRESENT: begin
                    if (accept) begin
                        // out_data keeps the last transferred word when leaving for IDLE or GAP
                        if (stop || stop_pend || oneshot_end) begin
                            state     <= IDLE;
                            stop_pend <= 1'b0;
                        end else if (DIV == 1) begin
                            out_data <= next_data;
                            bin      <= next_bin;
                        end else begin
                            state <= GAP;
                            presc <= 8'd0;
                        end
                    end else if (stop) begin
                        stop_pend <= 1'b1;
                    end
                end
                GAP: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (presc == GAP_LAST) begin
                        state    <= PRESENT;
                        out_data <= next_data;
                        bin      <= next_bin;
                    end else begin
                        presc <= presc + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: two WIDTH=4 instances (DIV=1 and DIV=3) sharing inputs,
// directed vector table, hand-written corner sequences and a random run against a word-index model.
module tb_pattern_gen;

`ifdef PATTERN_GEN_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       out_ready = 1'b0;

    logic       a_valid, a_busy, a_wrapped;
    logic [3:0] a_data;
    logic [1:0] a_dbg;
    logic       b_valid, b_busy, b_wrapped;
    logic [3:0] b_data;
    logic [1:0] b_dbg;

    pattern_gen #(.WIDTH(4), .DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .out_ready(out_ready), .out_valid(a_valid), .out_data(a_data),
        .busy(a_busy), .wrapped(a_wrapped), .dbg_state(a_dbg)
    );

    pattern_gen #(.WIDTH(4), .DIV(3)) u_div3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .out_ready(out_ready), .out_valid(b_valid), .out_data(b_data),
        .busy(b_busy), .wrapped(b_wrapped), .dbg_state(b_dbg)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: word index k within the sequence, phase, gap countdown
    int m_ph[2];
    int m_k[2];
    int m_mode[2];
    int m_gap[2];
    bit m_sp[2];
    int m_div[2] = '{1, 3};

    function automatic int word_of(input int md, input int k);
        int j = k % 16;
        case (md)
            0:       return j;
            1:       return 15 - j;
            2:       return 1 << (k % 4);
            default: return j ^ (j >> 1);
        endcase
    endfunction

    function automatic bit is_final(input int md, input int k);
        int per = (md == 2) ? 4 : 16;
        return (k % per) == (per - 1);
    endfunction

    task automatic model_step(input int i);
        case (m_ph[i])
            0: if (!stop && start) begin
                m_ph[i] = 1; m_mode[i] = int'(mode); m_k[i] = 0; m_sp[i] = 1'b0;
            end
            1: begin
                if (out_ready) begin
                    if (stop || m_sp[i]) begin
                        m_ph[i] = 0; m_sp[i] = 1'b0;
                    end else if (ONESHOT && is_final(m_mode[i], m_k[i])) begin
                        m_ph[i] = 0;
                    end else if (m_div[i] == 1) begin
                        m_k[i]++;
                    end else begin
                        m_ph[i] = 2; m_gap[i] = m_div[i] - 1;
                    end
                end else if (stop) begin
                    m_sp[i] = 1'b1;
                end
            end
            default: begin
                if (stop) begin
                    m_ph[i] = 0;
                end else begin
                    m_gap[i]--;
                    if (m_gap[i] == 0) begin
                        m_ph[i] = 1; m_k[i]++;
                    end
                end
            end
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_ph[i] = 0; m_k[i] = 0; m_mode[i] = 0; m_gap[i] = 0; m_sp[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    task automatic check_model(input int i);
        logic ev, eb, ew;
        logic [3:0] ed;
        ev = (m_ph[i] == 1);
        eb = (m_ph[i] != 0);
        ed = 4'(word_of(m_mode[i], m_k[i]));
        ew = ev && out_ready && is_final(m_mode[i], m_k[i]);
        if (i == 0) begin
            check("rnd_d1_valid", 32'(a_valid), 32'(ev));
            check("rnd_d1_busy", 32'(a_busy), 32'(eb));
            check("rnd_d1_data", 32'(a_data), 32'(ed));
            check("rnd_d1_wrapped", 32'(a_wrapped), 32'(ew));
        end else begin
            check("rnd_d3_valid", 32'(b_valid), 32'(ev));
            check("rnd_d3_busy", 32'(b_busy), 32'(eb));
            check("rnd_d3_data", 32'(b_data), 32'(ed));
            check("rnd_d3_wrapped", 32'(b_wrapped), 32'(ew));
        end
    endtask

    // driver tasks: inputs change on the falling edge, outputs sampled 1 time unit later
    task automatic cyc(input bit s, input bit p, input logic [1:0] md, input bit r);
        @(negedge clk);
        start = s; stop = p; mode = md; out_ready = r;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_a(input string tag, input bit ev, input logic [3:0] ed, input bit ew, input bit eb);
        check({tag, "_valid"}, 32'(a_valid), 32'(ev));
        check({tag, "_data"}, 32'(a_data), 32'(ed));
        check({tag, "_wrapped"}, 32'(a_wrapped), 32'(ew));
        check({tag, "_busy"}, 32'(a_busy), 32'(eb));
    endtask

    typedef struct {
        bit         s;
        bit         p;
        logic [1:0] md;
        bit         r;
        bit         ev;
        logic [3:0] ed;
        bit         ew;
        bit         eb;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit s, bit p, logic [1:0] md, bit r, bit ev, logic [3:0] ed, bit ew, bit eb);
        vec_t v;
        v.s = s; v.p = p; v.md = md; v.r = r; v.ev = ev; v.ed = ed; v.ew = ew; v.eb = eb;
        return v;
    endfunction

    initial begin
        // directed table on the DIV=1 instance: hold, ignored mode change, stop handling, walking one
        tbl.push_back(mk(1, 0, 2'b01, 0, 0, 4'h0, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 2'b00, 0, 1, 4'hF, 0, 1));
        tbl.push_back(mk(0, 0, 2'b00, 1, 1, 4'hF, 0, 1));
        tbl.push_back(mk(0, 0, 2'b00, 0, 1, 4'hE, 0, 1));
        tbl.push_back(mk(0, 1, 2'b00, 1, 1, 4'hE, 0, 1));
        tbl.push_back(mk(0, 0, 2'b00, 0, 0, 4'hE, 0, 0));
        tbl.push_back(mk(1, 1, 2'b10, 0, 0, 4'hE, 0, 0));
        tbl.push_back(mk(0, 0, 2'b10, 0, 0, 4'hE, 0, 0));
        tbl.push_back(mk(1, 0, 2'b10, 1, 0, 4'hE, 0, 0));
        tbl.push_back(mk(0, 0, 2'b00, 1, 1, 4'h1, 0, 1));
        tbl.push_back(mk(0, 0, 2'b00, 1, 1, 4'h2, 0, 1));
        tbl.push_back(mk(0, 0, 2'b00, 1, 1, 4'h4, 0, 1));
        tbl.push_back(mk(0, 0, 2'b00, 1, 1, 4'h8, 1, 1));
        if (ONESHOT) begin
            tbl.push_back(mk(0, 0, 2'b00, 1, 0, 4'h8, 0, 0));
            tbl.push_back(mk(0, 1, 2'b00, 1, 0, 4'h8, 0, 0));
            tbl.push_back(mk(0, 0, 2'b00, 0, 0, 4'h8, 0, 0));
        end else begin
            tbl.push_back(mk(0, 0, 2'b00, 1, 1, 4'h1, 0, 1));
            tbl.push_back(mk(0, 1, 2'b00, 1, 1, 4'h2, 0, 1));
            tbl.push_back(mk(0, 0, 2'b00, 0, 0, 4'h2, 0, 0));
        end

        // reset state
        #1;
        chk_a("rst_d1", 0, 4'h0, 0, 0);
        check("rst_d3_valid", 32'(b_valid), 32'd0);
        check("rst_d3_data", 32'(b_data), 32'd0);
        do_reset();

        foreach (tbl[n]) begin
            cyc(tbl[n].s, tbl[n].p, tbl[n].md, tbl[n].r);
            chk_a($sformatf("tbl%0d", n), tbl[n].ev, tbl[n].ed, tbl[n].ew, tbl[n].eb);
        end

        // up-count full period, DIV=1, ready held
        do_reset();
        cyc(1, 0, 2'b00, 1);
        chk_a("up_start", 0, 4'h0, 0, 0);
        for (int i = 0; i <= 16; i++) begin
            cyc(0, 0, 2'b00, 1);
            if (ONESHOT && i == 16) chk_a("up_done", 0, 4'hF, 0, 0);
            else chk_a($sformatf("up%0d", i), 1, 4'(i % 16), (i == 15), 1);
        end

        // walking one with DIV=3: one valid cycle then two gap cycles
        do_reset();
        cyc(1, 0, 2'b10, 1);
        for (int c = 0; c <= 12; c++) begin
            cyc(0, 0, 2'b00, 1);
            if (ONESHOT && c >= 10) begin
                check($sformatf("walk%0d_busy", c), 32'(b_busy), 32'd0);
                check($sformatf("walk%0d_valid", c), 32'(b_valid), 32'd0);
            end else begin
                check($sformatf("walk%0d_valid", c), 32'(b_valid), 32'(c % 3 == 0));
                if (c % 3 == 0) begin
                    check($sformatf("walk%0d_data", c), 32'(b_data), 32'(1 << ((c / 3) % 4)));
                    check($sformatf("walk%0d_wrapped", c), 32'(b_wrapped), 32'(((c / 3) % 4) == 3));
                end
            end
        end

        // Gray: stop pulsed while 0011 is held, then accepted
        do_reset();
        cyc(1, 0, 2'b11, 1);
        cyc(0, 0, 2'b00, 1);
        chk_a("gray0", 1, 4'h0, 0, 1);
        cyc(0, 0, 2'b00, 1);
        chk_a("gray1", 1, 4'h1, 0, 1);
        cyc(0, 1, 2'b00, 0);
        chk_a("gray_stop", 1, 4'h3, 0, 1);
        cyc(0, 0, 2'b00, 0);
        chk_a("gray_hold1", 1, 4'h3, 0, 1);
        cyc(0, 0, 2'b00, 0);
        chk_a("gray_hold2", 1, 4'h3, 0, 1);
        cyc(0, 0, 2'b00, 1);
        chk_a("gray_acc", 1, 4'h3, 0, 1);
        cyc(0, 0, 2'b00, 0);
        chk_a("gray_idle", 0, 4'h3, 0, 0);

        // asynchronous reset mid-run, then restart at the seed
        do_reset();
        cyc(1, 0, 2'b00, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 2'b00, 1);
        chk_a("pre_rst", 1, 4'h3, 0, 1);
        rst = 1'b1;
        #1;
        chk_a("async_rst", 0, 4'h0, 0, 0);
        #1;
        rst = 1'b0;
        cyc(0, 0, 2'b00, 1);
        chk_a("post_rst_idle", 0, 4'h0, 0, 0);
        cyc(1, 0, 2'b01, 1);
        cyc(0, 0, 2'b00, 1);
        chk_a("post_rst_seed", 1, 4'hF, 0, 1);

        // random run against the model, both instances
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
            check_model(0);
            check_model(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data word width in bits (legal range 2..32).
REQ-002 SHALL provide parameter DIV, default 1, minimum clock cycles from one accepted word to the next presented word (legal range 1..255).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL provide port start  input  1  begin a sequence; sampled only in IDLE.
REQ-006 SHALL provide port stop  input  1  end the current sequence.
REQ-007 SHALL provide port mode  input  2  pattern select; sampled only when start is accepted.
REQ-008 SHALL provide port out_ready  input  1  downstream consumer can accept out_data.
REQ-009 SHALL provide port out_valid  output  1  out_data holds a valid word.
REQ-010 SHALL provide port out_data  output  WIDTH  generated word, fed to the downstream WIDTH-parameterised stage.
REQ-011 SHALL provide port busy  output  1  high in every state except IDLE.
REQ-012 SHALL provide port wrapped  output  1  one-cycle pulse when the last word of a pattern period is accepted.

Function
REQ-013 SHALL implement states IDLE, PRESENT (out_valid=1) and GAP (out_valid=0, prescaler running).
REQ-014 SHALL treat a word as accepted only in a cycle where out_valid and out_ready are both 1.
REQ-015 SHALL, on start in IDLE, latch mode, load the mode's seed word and enter PRESENT on the next edge (latency 1 clock).
REQ-016 SHALL use these seed words: mode 00 up-count 0; mode 01 down-count all-ones; mode 10 walking-one 1 (bit 0 set); mode 11 Gray code of an internal binary counter starting at 0.
REQ-017 SHALL hold out_data and out_valid stable in PRESENT until the word is accepted; a presented word is never retracted.
REQ-018 SHALL, on acceptance with DIV=1, present the next word on the next edge with out_valid continuously high.
REQ-019 SHALL, on acceptance with DIV>1, enter GAP for exactly DIV-1 cycles, then present the next word.
REQ-020 SHALL advance the patterns as follows: 00 +1 modulo 2^WIDTH; 01 -1 modulo 2^WIDTH; 10 rotate left by 1 with MSB returning to bit 0; 11 binary counter +1, out_data = bin ^ (bin >> 1).
REQ-021 SHALL pulse wrapped for the acceptance cycle of the period-final word: 00 all-ones; 01 zero; 10 MSB set; 11 binary counter all-ones.
REQ-022 SHALL ignore mode changes while busy, and ignore start while busy.
REQ-023 SHALL, on stop in GAP, return to IDLE on the next edge.
REQ-024 SHALL, on stop in PRESENT, keep the current word valid until accepted and then enter IDLE (stop is remembered if deasserted before acceptance).
REQ-025 SHALL give stop priority over start when both are high in IDLE: remain in IDLE.
REQ-026 SHALL hold out_data at its last value in IDLE and drive out_valid=0 there.

Reset
REQ-027 SHALL, while rst=1, force state IDLE, out_valid=0, out_data=0, busy=0, wrapped=0, prescaler and counters 0, with no clock edge required.
REQ-028 SHALL discard any word in flight when reset asserts mid-sequence; after release, it SHALL wait for a new start.

Configuration
REQ-029 SHALL honour macro PATTERN_GEN_ONESHOT_EN: when defined, it SHALL return to IDLE immediately after the wrapped acceptance (one full period per start); when undefined, it SHALL continue free-running into the next period until stop.

Verification
REQ-030 SHALL pass: WIDTH=4, DIV=1, mode 00, out_ready=1 held -> out_data 0,1,...,15,0 on consecutive cycles; wrapped high only on the 15 acceptance.
REQ-031 SHALL pass: WIDTH=4, DIV=3, mode 10, out_ready=1 -> words 0001,0010,0100,1000,0001, each valid 1 cycle, then 2 gap cycles; wrapped on 1000.
REQ-032 SHALL pass: WIDTH=4, mode 01, out_ready low 5 cycles after start -> out_data=1111 and out_valid=1 stable for all 5 cycles; 1110 follows acceptance.
REQ-033 SHALL pass: WIDTH=4, mode 11, stop pulsed while word 0011 is held with out_ready=0 -> 0011 stays valid; on acceptance it enters IDLE, busy=0.
REQ-034 SHALL pass: rst asserted mid-run with out_valid=1 -> out_valid, out_data, busy drop to 0 asynchronously; start after release restarts at the seed word.
REQ-035 SHALL pass: with PATTERN_GEN_ONESHOT_EN defined, WIDTH=4, mode 00 -> exactly 16 words accepted, then busy=0; without the macro, word 0 follows 15.
